// File: rtl/avalon_slave_mem_if.sv
// Avalon-MM bus bundle between a CPU master port and the avalon_slave_mem responder.
interface avalon_slave_mem_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/avalon_slave_mem.sv
// Byte-enabled Avalon-MM word RAM with programmable wait states and a sticky protocol-fault flag.
// Define AVS_RANDOM_STALL_EN to add an LFSR-driven 0..3 extra stall cycles per transfer.
module avalon_slave_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter              INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               reset,
    avalon_slave_mem_if.slave  bus,
    output logic               fault
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {IDLE, STALL} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt, cnt_nx;
    logic [4:0]  stall_total;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [3:0]  l_be;
    logic        l_read, l_write;

    logic [31:0] offset;
    logic [AW-1:0] index;
    logic        req, in_range, legal, fields_same;
    logic        accept, bad, latch_en, do_write;

`ifdef AVS_RANDOM_STALL_EN
    logic [7:0] lfsr;
    assign stall_total = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};

    // x^8+x^6+x^5+x^4+1, advanced once per accepted transfer
    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= 8'hA5;
        else if (accept)
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`else
    assign stall_total = 5'(WAIT_CYCLES);
`endif

    assign req      = bus.read | bus.write;
    assign offset   = bus.address - BASE_ADDR;
    assign index    = offset[AW+1:2];
    assign in_range = ({2'b00, offset[31:2]} < 32'(DEPTH_WORDS));
    assign legal    = !(bus.read && bus.write) && (offset[1:0] == 2'b00) && in_range;

    assign fields_same = (bus.address == l_addr) && (bus.read == l_read) &&
                         (bus.write == l_write) && (bus.byteenable == l_be) &&
                         (bus.writedata == l_wdata);

    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    always_comb begin
        state_nx        = state;
        cnt_nx          = cnt;
        bus.waitrequest = 1'b0;
        bus.readdata    = 32'h0;
        accept          = 1'b0;
        bad             = 1'b0;
        latch_en        = 1'b0;
        do_write        = 1'b0;

        if (reset) begin
            bus.waitrequest = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        if (stall_total == 5'd0) begin
                            accept = 1'b1;
                        end else begin
                            bus.waitrequest = 1'b1;
                            latch_en        = 1'b1;
                            cnt_nx          = 5'd1;
                            state_nx        = STALL;
                        end
                    end
                end
                STALL: begin
                    if (!req || !fields_same) begin
                        // master broke the handshake: finish the transfer as a no-op
                        bad      = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = 5'd0;
                    end else if (cnt == stall_total) begin
                        accept   = 1'b1;
                        state_nx = IDLE;
                        cnt_nx   = 5'd0;
                    end else begin
                        bus.waitrequest = 1'b1;
                        cnt_nx          = cnt + 5'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (accept) begin
                if (legal) begin
                    if (bus.read)
                        bus.readdata = mem[index];
                    do_write = bus.write;
                end else begin
                    bad = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            fault <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (bad)
                fault <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en) begin
            l_addr  <= bus.address;
            l_read  <= bus.read;
            l_write <= bus.write;
            l_be    <= bus.byteenable;
            l_wdata <= bus.writedata;
        end
    end

    // NOTE: the RAM array has no reset; contents survive reset and map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.byteenable[i])
                    mem[index][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_avalon_slave_mem.sv
// Scoreboard bench for avalon_slave_mem: one instance with 2 wait states, one with none.
module tb_avalon_slave_mem;
    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    logic fault0, fault2;

    always #5 clk = ~clk;

    avalon_slave_mem_if bus0 ();
    avalon_slave_mem_if bus2 ();

    avalon_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .fault(fault0)
    );
    avalon_slave_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2), .fault(fault2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] model [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (sel == 0) begin
            bus0.read = rd; bus0.write = wr; bus0.address = a; bus0.writedata = d; bus0.byteenable = be;
        end else begin
            bus2.read = rd; bus2.write = wr; bus2.address = a; bus2.writedata = d; bus2.byteenable = be;
        end
    endtask

    function automatic logic get_wait(input int sel);
        return (sel == 0) ? bus0.waitrequest : bus2.waitrequest;
    endfunction

    function automatic logic [31:0] get_rdata(input int sel);
        return (sel == 0) ? bus0.readdata : bus2.readdata;
    endfunction

    function automatic logic get_fault(input int sel);
        return (sel == 0) ? fault0 : fault2;
    endfunction

    // Holds the request until waitrequest drops; pops the scoreboard on the accept cycle.
    task automatic xfer(input int sel, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input bit chk,
                        output int stalls);
        int cyc = 0;
        bit done = 0;
        logic [31:0] exp;
        @(negedge clk);
        drive(sel, rd, wr, a, d, be);
        while (!done) begin
            #1;
            if (!get_wait(sel)) begin
                done = 1;
            end else if (cyc >= 40) begin
                check("timeout", {31'b0, get_wait(sel)}, 32'h0);
                done = 1;
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        stalls = cyc;
        if (chk) begin
            exp = exp_q.pop_front();
            check("rdata", get_rdata(sel), exp);
        end
    endtask

    task automatic idle(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
    endtask

    task automatic do_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input int exp_st);
        int st;
        int idx = int'((a - BASE) >> 2);
        logic [31:0] w = model.exists(idx) ? model[idx] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (be[i]) w[8*i +: 8] = d[8*i +: 8];
        model[idx] = w;
        xfer(sel, 1'b0, 1'b1, a, d, be, 1'b0, st);
        check("write_stalls", st, exp_st);
    endtask

    task automatic do_read(input int sel, input logic [31:0] a, input int exp_st);
        int st;
        int idx = int'((a - BASE) >> 2);
        exp_q.push_back(model[idx]);
        xfer(sel, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, st);
        check("read_stalls", st, exp_st);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        #1;
        check("rst_wait2", {31'b0, bus2.waitrequest}, 32'h1);
        check("rst_fault2", {31'b0, fault2}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int st;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_wait0", {31'b0, bus0.waitrequest}, 32'h1);
        check("rst_wait2", {31'b0, bus2.waitrequest}, 32'h1);
        check("rst_rdata2", bus2.readdata, 32'h0);
        check("rst_fault0", {31'b0, fault0}, 32'h0);
        check("rst_fault2", {31'b0, fault2}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("idle_wait2", {31'b0, bus2.waitrequest}, 32'h0);
        check("idle_rdata2", bus2.readdata, 32'h0);

        // two-wait-state instance: image word, byte lanes, empty byteenable
        do_write(2, BASE, 32'h3C021234, 4'hF, 2);
        do_write(2, BASE + 32'h10, 32'h0, 4'hF, 2);
        do_write(2, BASE + 32'h20, 32'h11223344, 4'hF, 2);
        do_write(2, BASE + 32'h30, 32'h55AA55AA, 4'hF, 2);
        do_read(2, BASE, 2);
        do_write(2, BASE + 32'h10, 32'hAABBCCDD, 4'b0101, 2);
        do_read(2, BASE + 32'h10, 2);
        check("lanes_const", model[4], 32'h00BB00DD);
        do_write(2, BASE + 32'h10, 32'hFFFFFFFF, 4'b0000, 2);
        do_read(2, BASE + 32'h10, 2);
        idle(2);
        check("fault_clean", {31'b0, fault2}, 32'h0);

        // read and write together
        exp_q.push_back(32'h0);
        xfer(2, 1'b1, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, st);
        idle(2);
        check("rdwr_fault", {31'b0, fault2}, 32'h1);
        do_read(2, BASE + 32'h20, 2);
        pulse_reset();

        // misaligned write must not land in word 0
        xfer(2, 1'b0, 1'b1, BASE + 32'h2, 32'h0, 4'hF, 1'b0, st);
        idle(2);
        check("misalign_fault", {31'b0, fault2}, 32'h1);
        do_read(2, BASE, 2);
        pulse_reset();

        // one past the window
        exp_q.push_back(32'h0);
        xfer(2, 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, 1'b1, st);
        idle(2);
        check("oor_fault", {31'b0, fault2}, 32'h1);
        do_read(2, BASE + 32'h10, 2);
        idle(2);
        check("fault_sticky", {31'b0, get_fault(2)}, 32'h1);

        // reset while a write is stalled
        @(negedge clk);
        drive(2, 1'b0, 1'b1, BASE + 32'h30, 32'h99999999, 4'hF);
        #1;
        check("stall_wait", {31'b0, get_wait(2)}, 32'h1);
        @(negedge clk);
        reset = 1'b1;
        drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("midrst_wait", {31'b0, get_wait(2)}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_fault", {31'b0, fault2}, 32'h0);
        check("midrst_idle", {31'b0, get_wait(2)}, 32'h0);
        do_read(2, BASE + 32'h30, 2);
        idle(2);

        // zero-wait instance: back-to-back read, write, read
        do_write(0, BASE + 32'h40, 32'hDEADBEEF, 4'hF, 0);
        do_read(0, BASE + 32'h40, 0);
        do_write(0, BASE + 32'h40, 32'h12345678, 4'hF, 0);
        do_read(0, BASE + 32'h40, 0);
        idle(0);
        check("fault0_clean", {31'b0, fault0}, 32'h0);
        check("sb_empty", 32'(exp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
